// File: rtl/firebird7_in_gate1_ijtag_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : firebird7_in_gate1_ijtag_pkg
//  Brief    : Shared constants for the gate1 IJTAG segment (mux width and
//             TDR field positions).
//  Revision : 1.0 - initial release
// ============================================================================
package firebird7_in_gate1_ijtag_pkg;

    // Width of the gate1 w19 data mux data path.
    localparam int unsigned GATE1_MUX_W = 19;

    // Field positions inside a gate1 data TDR: select sits above the data.
    localparam int unsigned SEL_BIT     = GATE1_MUX_W;
    localparam int unsigned DATA_LSB    = 0;

endpackage
`default_nettype wire

// File: rtl/firebird7_in_gate1_tessent_tdr_data_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : firebird7_in_gate1_tessent_tdr_data_ctrl
//  Brief    : IJTAG TDR driving the gate1 w19 data mux select and data.
//             Capture/shift on TCK rising edge, update and scan-out retime
//             on TCK falling edge. Capture observes the functional mux input
//             and the current select state.
//  Revision : 1.0 - initial release
// ============================================================================
module firebird7_in_gate1_tessent_tdr_data_ctrl
    import firebird7_in_gate1_ijtag_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = GATE1_MUX_W,
    parameter logic [DATA_WIDTH-1:0] DATA_RESET   = '0,
    parameter logic                  SELECT_RESET = 1'b0
) (
    input  logic                  ijtag_tck,
    input  logic                  ijtag_reset,
    input  logic                  ijtag_sel,
    input  logic                  ijtag_ce,
    input  logic                  ijtag_se,
    input  logic                  ijtag_ue,
    input  logic                  ijtag_si,
    output logic                  ijtag_so,
    input  logic [DATA_WIDTH-1:0] functional_data_obs,
    output logic                  ijtag_select,
    output logic [DATA_WIDTH-1:0] ijtag_data_out
);

    // Select field lives directly above the data field in the chain.
    localparam int unsigned c_sel_bit = DATA_WIDTH;

    logic [DATA_WIDTH:0]   r_shift;
    logic                  r_upd_select;
    logic [DATA_WIDTH-1:0] r_upd_data;
    logic                  r_so_retime;
    logic [DATA_WIDTH:0]   w_capture_word;

    // Capture word: current select state plus what the mux sees functionally.
    assign w_capture_word = {r_upd_select, functional_data_obs};

    // Shift chain: capture wins over shift; LSB leaves first, SI enters at MSB.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            r_shift <= '0;
        end else if (ijtag_sel) begin
            if (ijtag_ce) begin
                r_shift <= w_capture_word;
            end else if (ijtag_se) begin
                r_shift <= {ijtag_si, r_shift[DATA_WIDTH:1]};
            end
        end
    end

    // Update registers on the falling edge so shifting never disturbs the mux.
    always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            r_upd_select <= SELECT_RESET;
            r_upd_data   <= DATA_RESET;
        end else if (ijtag_sel && ijtag_ue) begin
            r_upd_select <= r_shift[c_sel_bit];
            r_upd_data   <= r_shift[DATA_WIDTH-1:DATA_LSB];
        end
    end

    // Scan-out retime on the falling edge for hold margin to the next TDR.
    always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            r_so_retime <= 1'b0;
        end else if (ijtag_sel) begin
            r_so_retime <= r_shift[0];
        end
    end

    assign ijtag_so       = r_so_retime;
    assign ijtag_select   = r_upd_select;
    assign ijtag_data_out = r_upd_data;

endmodule
`default_nettype wire

// File: tb/tb_firebird7_in_gate1_tessent_tdr_data_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_firebird7_in_gate1_tessent_tdr_data_ctrl
//  Brief    : Self-checking bench for the gate1 data TDR, directed scenarios
//             plus randomized traffic against a behavioural chain model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_firebird7_in_gate1_tessent_tdr_data_ctrl;

    localparam int W = 19;
    localparam int L = W + 1;

    logic         tck = 1'b0;
    logic         rst_n;
    logic         sel, ce, se, ue, si;
    logic [W-1:0] fdo;
    logic         so;
    logic         dut_select;
    logic [W-1:0] dut_data;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: chain as a plain integer, bit 0 is next to leave.
    int unsigned m_chain;
    int unsigned m_upd_sel;
    int unsigned m_upd_data;
    int unsigned m_so;

    always #5 tck = ~tck;

    firebird7_in_gate1_tessent_tdr_data_ctrl dut (
        .ijtag_tck           (tck),
        .ijtag_reset         (rst_n),
        .ijtag_sel           (sel),
        .ijtag_ce            (ce),
        .ijtag_se            (se),
        .ijtag_ue            (ue),
        .ijtag_si            (si),
        .ijtag_so            (so),
        .functional_data_obs (fdo),
        .ijtag_select        (dut_select),
        .ijtag_data_out      (dut_data)
    );

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_chain    = 0;
        m_upd_sel  = 0;
        m_upd_data = 0;
        m_so       = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_select"}, {31'd0, dut_select}, m_upd_sel);
        check_eq({tag, "_data"},   {13'd0, dut_data},   m_upd_data);
        check_eq({tag, "_so"},     {31'd0, so},         m_so);
    endtask

    // One TCK cycle; entered and left just after a falling edge.
    task automatic cycle(input logic s, input logic c, input logic e,
                         input logic u, input logic d, input logic [W-1:0] f);
        sel = s; ce = c; se = e; ue = u; si = d; fdo = f;
        @(posedge tck);
        if (s) begin
            if (c)      m_chain = (m_upd_sel << W) + int'(f);
            else if (e) m_chain = (m_chain / 2) + (int'(d) << W);
        end
        #1;
        check_outputs("pos");
        @(negedge tck);
        if (s && u) begin
            m_upd_sel  = m_chain / (1 << W);
            m_upd_data = m_chain % (1 << W);
        end
        if (s) m_so = m_chain % 2;
        #1;
        check_outputs("neg");
    endtask

    // Shift a whole word in (LSB first); ue held low.
    task automatic shift_word(input int unsigned word);
        for (int i = 0; i < L; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'((word >> i) & 1), 19'($urandom));
        end
    endtask

    initial begin
        logic [W-1:0] rnd;
        sel = 0; ce = 0; se = 0; ue = 0; si = 0; fdo = '0;
        rst_n = 1'b0;
        model_reset();
        #3;
        check_eq("reset_select", {31'd0, dut_select}, 0);
        check_eq("reset_data",   {13'd0, dut_data},   0);
        check_eq("reset_so",     {31'd0, so},         0);
        @(negedge tck); #1;
        rst_n = 1'b1;

        // Load select=1, data=5A5A5 and update.
        shift_word((1 << W) | 32'h5A5A5);
        check_eq("pre_update_select", {31'd0, dut_select}, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check_eq("load_select", {31'd0, dut_select}, 1);
        check_eq("load_data",   {13'd0, dut_data},   32'h5A5A5);

        // Shift without update keeps the mux controls steady.
        for (int i = 0; i < L; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'($urandom), 19'($urandom));
            check_eq("noupd_data",   {13'd0, dut_data},   32'h5A5A5);
            check_eq("noupd_select", {31'd0, dut_select}, 1);
        end

        // Capture all-ones functional data with select=1, read back 20 ones.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 19'h7FFFF);
        check_eq("cap_bit0", {31'd0, so}, 1);
        for (int i = 1; i < L; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'($urandom), '0);
            check_eq("cap_bit", {31'd0, so}, 1);
        end

        // Capture beats shift when both are asserted.
        rnd = 19'($urandom);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, rnd);
        check_eq("prio_bit0", {31'd0, so}, int'(rnd[0]));
        for (int i = 1; i < L; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
            check_eq("prio_bit", {31'd0, so}, (i < W) ? int'(rnd[i]) : 1);
        end

        // Deselected: nothing moves whatever the controls do.
        shift_word(32'($urandom) & 32'hFFFFF);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 19'($urandom));
        end
        // Chain contents survived: shift out and compare through the model.
        for (int i = 0; i < L; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'($urandom), '0);
        end

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0), 1'($urandom),
                  ($urandom_range(0, 5) == 0), 1'($urandom), 19'($urandom));
        end

        // Asynchronous reset in the middle of a shift, while TCK is high.
        shift_word(32'hFFFFF);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        sel = 1; se = 1; ce = 0; ue = 0; si = 1;
        @(posedge tck);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("midreset_select", {31'd0, dut_select}, 0);
        check_eq("midreset_data",   {13'd0, dut_data},   0);
        check_eq("midreset_so",     {31'd0, so},         0);
        @(negedge tck); #1;
        check_outputs("in_reset");
        rst_n = 1'b1;
        // Chain was cleared: reading out gives zeros.
        for (int i = 0; i < L; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
            check_eq("post_reset_so", {31'd0, so}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/firebird7_in_gate1_tessent_tdr_data_ctrl.md
Name: firebird7_in_gate1_tessent_tdr_data_ctrl

Overview:
- IJTAG test data register (TDR) that directly feeds the gate1 w19 data mux. It drives the mux's ijtag_select and its 19-bit ijtag_data_in.
- Controlled entirely from the IJTAG network via capture/shift/update on ijtag_tck.
- Capture observes the mux's functional-side input and the current select state, so patterns can read back what the mux would pass in mission mode.
- One instance per data mux, placed in the gate1 IJTAG segment next to its mux.

Parameters:
- DATA_WIDTH, 19, width of the data field; the shift chain length is DATA_WIDTH+1.
- DATA_RESET, 19'h0, reset value of the data update register.
- SELECT_RESET, 1'b0, reset value of the select update bit; 0 means the mux passes functional data.

Ports:
- ijtag_tck  input  1  IJTAG test clock, the only clock.
- ijtag_reset  input  1  asynchronous active-low reset.
- ijtag_sel  input  1  this TDR is on the active scan path.
- ijtag_ce  input  1  capture enable.
- ijtag_se  input  1  shift enable.
- ijtag_ue  input  1  update enable.
- ijtag_si  input  1  scan in.
- ijtag_so  output  1  scan out.
- functional_data_obs  input  DATA_WIDTH  copy of the mux's functional_data_in, captured for observation.
- ijtag_select  output  1  drives the mux's ijtag_select.
- ijtag_data_out  output  DATA_WIDTH  drives the mux's ijtag_data_in.

Behaviour:
- Storage:
  - shift_reg[DATA_WIDTH:0]: bit DATA_WIDTH is the select field, bits [DATA_WIDTH-1:0] are the data field.
  - upd_select, upd_data: the update registers.
  - so_retime: 1-bit scan-out retiming flop.
- Reset (ijtag_reset=0, asynchronous, any time, including mid-shift):
  - shift_reg=0, upd_data=DATA_RESET, upd_select=SELECT_RESET, so_retime=0.
  - Outputs follow immediately: ijtag_select=SELECT_RESET, ijtag_data_out=DATA_RESET, ijtag_so=0.
- Shift register, posedge ijtag_tck, only when ijtag_sel=1:
  - ce=1: shift_reg <= {upd_select, functional_data_obs}. Capture has priority over shift if both are asserted.
  - else se=1: shift_reg <= {ijtag_si, shift_reg[DATA_WIDTH:1]}. Data is LSB-first out, MSB-first in.
  - otherwise: hold.
- ijtag_sel=0: shift_reg holds regardless of ce/se.
- Update registers, negedge ijtag_tck:
  - When ijtag_sel=1 and ijtag_ue=1: {upd_select, upd_data} <= shift_reg.
  - Otherwise: hold.
  - An update in the same TCK cycle as a shift takes the post-shift value, which is the standard IEEE 1687 ordering.
- Scan out: so_retime <= shift_reg[0] on negedge ijtag_tck when ijtag_sel=1, else hold. ijtag_so = so_retime.
- Outputs: ijtag_select = upd_select, ijtag_data_out = upd_data, both directly from flops with no combinational path from inputs.
- Latency:
  - Full load needs DATA_WIDTH+1 shift cycles, then the ue negedge.
  - Outputs change at the negedge of the update cycle.
- Output glitch rule: the update registers change only on the ue negedge, so shifting never disturbs the mux.
- Asynchronous functional_data_obs: it is sampled only during capture. Capture timing is relaxed by test-mode constraints, and no synchronizer is required.

Decomposition:
- Shared package firebird7_in_gate1_ijtag_pkg holds:
  - localparam GATE1_MUX_W = 19;
  - the TDR field position constants SEL_BIT = GATE1_MUX_W and DATA_LSB = 0.
- Single module with no sub-module. The retiming flop is inline.

Test Plan:
- Reset: assert ijtag_reset=0 mid-shift -> ijtag_select=0, ijtag_data_out=19'h0, ijtag_so=0 immediately, with no wait for TCK.
- Load and update:
  - Stimulus: with sel=1, shift in 20 bits encoding select=1, data=19'h5A5A5 (LSB first), then pulse ue.
  - Response: ijtag_select=1 and ijtag_data_out=19'h5A5A5 after that negedge, and not before.
- Capture and readback:
  - Stimulus: functional_data_obs=19'h7FFFF, upd_select=1; pulse ce, then shift 20 cycles.
  - Response: ijtag_so emits 19 ones then a 1, each bit valid from the negedge.
- Deselect:
  - Stimulus: ijtag_sel=0 while ce/se/ue toggle with random si.
  - Response: shift_reg, update registers and ijtag_so are all unchanged.
- Priority: ce=1 and se=1 in the same cycle -> capture value is loaded, with no shift.
- Shift-without-update: shift a new pattern with ue held at 0 -> ijtag_select and ijtag_data_out keep the previous value (19'h5A5A5) throughout.
